shared_adder_ctrl: RTL and testbench

Controller that shares one combinational ripple adder (WIDTH-bit, carry-in, carry-out, with a modelled propagation delay) between two requesters in the processor datapath. It arbitrates requests, drives the adder inputs from registered operands, and waits a fixed number of clock cycles for the adder to settle. It then captures the sum and carry and returns them to the winning requester over a 4-phase req/done handshake.

---
 rtl/shared_adder_pkg.sv | 15 +
 rtl/shared_adder_if.sv | 41 ++++
 rtl/arb_pick2.sv | 32 +++
 rtl/shared_adder_ctrl.sv | 150 +++++++++++++++
 tb/tb_shared_adder_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/shared_adder_pkg.sv
// Shared definitions for the shared-adder controller: state encoding and default sizing.
// No logic; constants only.
// Imported by the interface, the arbiter and the controller.
package shared_adder_pkg;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_SETTLE = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

endpackage

// File: rtl/shared_adder_if.sv
// Bundle of requester operands/handshake, shared-adder port and result signals.
// Pure wiring, zero latency.
// master = requesters + adder side, slave = the controller.
interface shared_adder_if
    import shared_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             ci0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             ci1;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_ci;
    logic [WIDTH-1:0] add_sum;
    logic             add_co;

    logic [1:0]       gnt;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] sum_out;
    logic             co_out;
    logic             busy;

    modport master (
        output req0, req1, a0, b0, ci0, a1, b1, ci1, add_sum, add_co,
        input  add_a, add_b, add_ci, gnt, done0, done1, sum_out, co_out, busy
    );

    modport slave (
        input  req0, req1, a0, b0, ci0, a1, b1, ci1, add_sum, add_co,
        output add_a, add_b, add_ci, gnt, done0, done1, sum_out, co_out, busy
    );

endinterface

// File: rtl/arb_pick2.sv
// Two-way one-hot pick; SHARED_ADDER_RR_EN selects round-robin on ties, else req0 has priority.
// Combinational, zero latency.
// No backpressure; caller samples win only when it can accept.
module arb_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win
);

`ifdef SHARED_ADDER_RR_EN
    // last names the requester served most recently; the other one wins a tie.
    always_comb begin
        win = req;
        if (req == 2'b11) begin
            win = last ? 2'b01 : 2'b10;
        end
    end
`else
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        win = 2'b00;
        if (req[0]) begin
            win = 2'b01;
        end else if (req[1]) begin
            win = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/shared_adder_ctrl.sv
// Arbitrates two requesters onto one external adder; SHARED_ADDER_RR_EN enables round-robin ties.
// Latency: result/done SETTLE cycles after grant; release one edge after req drops.
// Backpressure: 4-phase req/done; a losing req stays pending until the controller is idle.
module shared_adder_ctrl
    import shared_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic          clk,
    input  logic          reset,
    shared_adder_if.slave bus
);

    localparam int            CW       = $clog2(SETTLE) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] add_a_q, add_a_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;
    logic             add_ci_q, add_ci_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             co_q, co_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;

    logic [1:0]       win;
    logic             last_sel;
    logic             gnt_req;

`ifdef SHARED_ADDER_RR_EN
    logic last_q, last_d;

    // Reset to 1 so requester 0 takes the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        last_d = last_q;
        if (state_q == ST_IDLE && win != 2'b00) begin
            last_d = win[1];
        end
    end

    assign last_sel = last_q;
`else
    assign last_sel = 1'b1;
`endif

    arb_pick2 u_pick (
        .req  ({bus.req1, bus.req0}),
        .last (last_sel),
        .win  (win)
    );

    assign gnt_req = (gnt_q[0] & bus.req0) | (gnt_q[1] & bus.req1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        add_a_d  = add_a_q;
        add_b_d  = add_b_q;
        add_ci_d = add_ci_q;
        sum_d    = sum_q;
        co_d     = co_q;
        gnt_d    = gnt_q;
        done0_d  = done0_q;
        done1_d  = done1_q;

        unique case (state_q)
            ST_IDLE: begin
                if (win != 2'b00) begin
                    add_a_d  = win[1] ? bus.a1  : bus.a0;
                    add_b_d  = win[1] ? bus.b1  : bus.b0;
                    add_ci_d = win[1] ? bus.ci1 : bus.ci0;
                    gnt_d    = win;
                    cnt_d    = CNT_LOAD;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // Adder operands were driven at grant; sample once the window elapses.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    sum_d   = bus.add_sum;
                    co_d    = bus.add_co;
                    done0_d = gnt_q[0];
                    done1_d = gnt_q[1];
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!gnt_req) begin
                    gnt_d   = 2'b00;
                    done0_d = 1'b0;
                    done1_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            add_a_q  <= '0;
            add_b_q  <= '0;
            add_ci_q <= 1'b0;
            sum_q    <= '0;
            co_q     <= 1'b0;
            gnt_q    <= 2'b00;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            add_a_q  <= add_a_d;
            add_b_q  <= add_b_d;
            add_ci_q <= add_ci_d;
            sum_q    <= sum_d;
            co_q     <= co_d;
            gnt_q    <= gnt_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
        end
    end

    assign bus.add_a   = add_a_q;
    assign bus.add_b   = add_b_q;
    assign bus.add_ci  = add_ci_q;
    assign bus.gnt     = gnt_q;
    assign bus.done0   = done0_q;
    assign bus.done1   = done1_q;
    assign bus.sum_out = sum_q;
    assign bus.co_out  = co_q;
    assign bus.busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shared_adder_ctrl.sv
// Directed + randomized bench for shared_adder_ctrl with a delayed-assign adder model.
// Expected results come from plain arithmetic and a served-last arbitration model.
module tb_shared_adder_ctrl;
    import shared_adder_pkg::*;

    localparam int WIDTH  = 4;
    localparam int SETTLE = 3;

    logic clk;
    logic reset;
    logic use_slow;

    int passed;
    int total;
    int last_served;
    int prev_true;
    int op_a [2];
    int op_b [2];
    int op_ci[2];

    shared_adder_if #(.WIDTH(WIDTH)) bus ();

    shared_adder_ctrl #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Adder with a short (settles in window) and a long (misses window) propagation delay.
    wire [WIDTH:0] fast_res;
    wire [WIDTH:0] slow_res;
    assign #7  fast_res = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{WIDTH{1'b0}}, bus.add_ci};
    assign #55 slow_res = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{WIDTH{1'b0}}, bus.add_ci};
    assign {bus.add_co, bus.add_sum} = use_slow ? slow_res : fast_res;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int pick_model(input logic [1:0] mask);
        if (mask == 2'b01) return 0;
        if (mask == 2'b10) return 1;
`ifdef SHARED_ADDER_RR_EN
        return (last_served == 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    function automatic logic done_of(input int w);
        return (w == 0) ? bus.done0 : bus.done1;
    endfunction

    task automatic drive_ops();
        bus.a0  = WIDTH'(op_a[0]);
        bus.b0  = WIDTH'(op_b[0]);
        bus.ci0 = op_ci[0][0];
        bus.a1  = WIDTH'(op_a[1]);
        bus.b1  = WIDTH'(op_b[1]);
        bus.ci1 = op_ci[1][0];
    endtask

    // One full transaction; returns the requester the bench expected to win.
    task automatic do_xact(input logic [1:0] mask, input bit drop_all, input string tag,
                           output int w);
        int true_res;
        int exp_res;
        int lat;
        w        = pick_model(mask);
        true_res = op_a[w] + op_b[w] + op_ci[w];
        exp_res  = use_slow ? prev_true : true_res;
        drive_ops();
        bus.req0 = mask[0];
        bus.req1 = mask[1];
        tick();
        chk({tag, "_gnt"},   32'(bus.gnt), 32'(1 << w));
        chk({tag, "_busy"},  32'(bus.busy), 32'd1);
        chk({tag, "_add_a"}, 32'(bus.add_a), 32'(op_a[w]));
        lat = 99;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (done_of(w) === 1'b1) begin
                lat = n;
                break;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'(SETTLE));
        chk({tag, "_done_other"}, 32'(done_of(1 - w)), 32'd0);
        chk({tag, "_result"}, 32'({bus.co_out, bus.sum_out}), 32'(exp_res));
        if (drop_all) begin
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
        end else if (w == 0) begin
            bus.req0 = 1'b0;
        end else begin
            bus.req1 = 1'b0;
        end
        tick();
        chk({tag, "_rel_gnt"},  32'(bus.gnt), 32'd0);
        chk({tag, "_rel_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_rel_done"}, 32'(done_of(w)), 32'd0);
        last_served = w;
        prev_true   = true_res;
    endtask

    initial begin
        int w;
        int order;
        int exp_order;
        logic [1:0] mask;

        passed = 0;
        total = 0;
        last_served = 1;
        prev_true = 0;
        use_slow = 1'b0;
        reset = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            op_a[i] = 0;
            op_b[i] = 0;
            op_ci[i] = 0;
        end
        drive_ops();

        tick();
        tick();
        chk("rst_gnt",   32'(bus.gnt), 32'd0);
        chk("rst_done",  32'({bus.done1, bus.done0}), 32'd0);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_res",   32'({bus.co_out, bus.sum_out}), 32'd0);
        chk("rst_adder", 32'({bus.add_ci, bus.add_a, bus.add_b}), 32'd0);
        reset = 1'b0;
        tick();

        // Single request, requester 0.
        op_a[0] = 10; op_b[0] = 3; op_ci[0] = 0;
        do_xact(2'b01, 1'b1, "single", w);

        // Full-width overflow on requester 1.
        op_a[1] = 15; op_b[1] = 15; op_ci[1] = 1;
        do_xact(2'b10, 1'b1, "ovf", w);

        // Tie with both requests held; the winner drops for one cycle and re-raises.
        op_a[0] = 7; op_b[0] = 2; op_ci[0] = 1;
        op_a[1] = 4; op_b[1] = 12; op_ci[1] = 0;
        order = 0;
        for (int t = 0; t < 3; t++) begin
            do_xact(2'b11, 1'b0, "tie", w);
            order = order * 10 + w;
        end
`ifdef SHARED_ADDER_RR_EN
        exp_order = 10;
`else
        exp_order = 0;
`endif
        chk("tie_order", 32'(order), 32'(exp_order));
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
        tick();
        tick();

        // Abort: req0 drops one cycle after grant; done0 pulses for exactly one cycle.
        op_a[0] = 5; op_b[0] = 6; op_ci[0] = 1;
        drive_ops();
        bus.req0 = 1'b1;
        tick();
        chk("abort_gnt", 32'(bus.gnt), 32'd1);
        tick();
        bus.req0 = 1'b0;
        tick();
        chk("abort_done_early", 32'(bus.done0), 32'd0);
        tick();
        chk("abort_done",   32'(bus.done0), 32'd1);
        chk("abort_result", 32'({bus.co_out, bus.sum_out}), 32'(5 + 6 + 1));
        tick();
        chk("abort_done_off", 32'(bus.done0), 32'd0);
        chk("abort_busy",     32'(bus.busy), 32'd0);
        last_served = 0;
        prev_true = 5 + 6 + 1;

        // Adder slower than the settle window: the captured value is the stale previous sum.
        for (int i = 0; i < 8; i++) tick();
        use_slow = 1'b1;
        op_a[0] = 1; op_b[0] = 2; op_ci[0] = 0;
        do_xact(2'b01, 1'b1, "slow", w);
        use_slow = 1'b0;
        tick();

        // Reset in the middle of SETTLE.
        op_a[0] = 9; op_b[0] = 9; op_ci[0] = 0;
        drive_ops();
        bus.req0 = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        bus.req0 = 1'b0;
        tick();
        chk("mid_rst_gnt",  32'(bus.gnt), 32'd0);
        chk("mid_rst_done", 32'({bus.done1, bus.done0}), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_res",  32'({bus.co_out, bus.sum_out}), 32'd0);
        chk("mid_rst_add",  32'({bus.add_ci, bus.add_a, bus.add_b}), 32'd0);
        reset = 1'b0;
        last_served = 1;
        prev_true = 0;
        tick();
        op_a[0] = 8; op_b[0] = 9; op_ci[0] = 1;
        do_xact(2'b01, 1'b1, "post_rst", w);

        // Randomized traffic.
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < 2; i++) begin
                op_a[i]  = int'($urandom_range(0, 15));
                op_b[i]  = int'($urandom_range(0, 15));
                op_ci[i] = int'($urandom_range(0, 1));
            end
            mask = 2'($urandom_range(1, 3));
            do_xact(mask, 1'b1, "rnd", w);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
